// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extender: format selector codes and skid-buffer states.
package imm_pkg;

  localparam int unsigned IMM_SRC_W = 3;
  localparam int unsigned INSTR_W   = 32;

  localparam logic [IMM_SRC_W-1:0] IMM_I   = 3'b000;
  localparam logic [IMM_SRC_W-1:0] IMM_S   = 3'b001;
  localparam logic [IMM_SRC_W-1:0] IMM_B   = 3'b010;
  localparam logic [IMM_SRC_W-1:0] IMM_J   = 3'b011;
  localparam logic [IMM_SRC_W-1:0] IMM_U   = 3'b100;
  localparam logic [IMM_SRC_W-1:0] IMM_Z   = 3'b101;
  localparam logic [IMM_SRC_W-1:0] IMM_SH  = 3'b110;
  localparam logic [IMM_SRC_W-1:0] IMM_ILL = 3'b111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-side handshake bus: instruction/tag in, extended immediate/tag out, plus flush.
interface imm_extend_pipe_if #(
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned TAG_WIDTH      = 5
);
  import imm_pkg::*;

  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [IMM_SRC_W-1:0]      imm_src;
  logic [INSTR_W-1:0]        instr;
  logic [TAG_WIDTH-1:0]      in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_BUS_WIDTH-1:0] extended_imm;
  logic [TAG_WIDTH-1:0]      out_tag;
  logic                      out_illegal;

  modport master (
    output flush, in_valid, imm_src, instr, in_tag, out_ready,
    input  in_ready, out_valid, extended_imm, out_tag, out_illegal
  );

  modport slave (
    input  flush, in_valid, imm_src, instr, in_tag, out_ready,
    output in_ready, out_valid, extended_imm, out_tag, out_illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate format mux; signed formats are built at 32 bits then widened to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 32
) (
  input  logic [IMM_SRC_W-1:0]      imm_src,
  input  logic [INSTR_W-1:0]        instr,
  output logic [DATA_BUS_WIDTH-1:0] imm,
  output logic                      illegal
);

  logic signed [31:0] simm_c;
  logic [5:0]         zimm_c;
  logic               use_zext_c;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    simm_c     = '0;
    zimm_c     = '0;
    use_zext_c = 1'b0;
    illegal    = 1'b0;
    case (imm_src)
      IMM_I:  simm_c = 32'($signed(instr[31:20]));
      IMM_S:  simm_c = 32'($signed({instr[31:25], instr[11:7]}));
      IMM_B:  simm_c = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:  simm_c = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:  simm_c = $signed({instr[31:12], 12'b0});
      IMM_Z: begin
        use_zext_c = 1'b1;
        zimm_c     = {1'b0, instr[19:15]};
      end
      IMM_SH: begin
        use_zext_c = 1'b1;
        zimm_c     = (DATA_BUS_WIDTH == 64) ? instr[25:20] : {1'b0, instr[24:20]};
      end
      default: illegal = 1'b1;
    endcase
    // Size cast of a signed operand sign-extends, giving the XLEN=64 widening for free
    imm = use_zext_c ? DATA_BUS_WIDTH'(zimm_c) : DATA_BUS_WIDTH'(simm_c);
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with a 2-entry skid buffer; in_ready never depends on out_ready combinationally.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter int unsigned TAG_WIDTH      = 5
) (
  input logic              clk,
  input logic              rst,
  imm_extend_pipe_if.slave bus
);

  typedef struct packed {
    logic [DATA_BUS_WIDTH-1:0] imm;
    logic [TAG_WIDTH-1:0]      tag;
    logic                      illegal;
  } entry_t;

  logic [DATA_BUS_WIDTH-1:0] dec_imm_c;
  logic                      dec_illegal_c;
  entry_t                    in_entry_c;
  entry_t                    main_q;
  entry_t                    skid_q;
  buf_state_e                state_q;
  buf_state_e                state_d;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      accept_c;
  logic                      drain_c;
  logic                      load_main_in_c;
  logic                      load_main_skid_c;
  logic                      load_skid_c;

  imm_decode #(.DATA_BUS_WIDTH(DATA_BUS_WIDTH)) u_imm_decode (
    .imm_src (bus.imm_src),
    .instr   (bus.instr),
    .imm     (dec_imm_c),
    .illegal (dec_illegal_c)
  );

  assign in_entry_c = '{imm: dec_imm_c, tag: bus.in_tag, illegal: dec_illegal_c};

  // Next-state and register-load selection; flush overrides everything
  always_comb begin
    state_d          = state_q;
    load_main_in_c   = 1'b0;
    load_main_skid_c = 1'b0;
    load_skid_c      = 1'b0;
    accept_c         = bus.in_valid & in_ready_q;
    drain_c          = out_valid_q & bus.out_ready;
    case (state_q)
      BUF_EMPTY: begin
        if (accept_c) begin
          state_d        = BUF_ONE;
          load_main_in_c = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept_c && drain_c) begin
          load_main_in_c = 1'b1;
        end else if (accept_c) begin
          state_d     = BUF_TWO;
          load_skid_c = 1'b1;
        end else if (drain_c) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (drain_c) begin
          state_d          = BUF_ONE;
          load_main_skid_c = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (bus.flush) begin
      state_d          = BUF_EMPTY;
      load_main_in_c   = 1'b0;
      load_main_skid_c = 1'b0;
      load_skid_c      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BUF_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != BUF_TWO);
      out_valid_q <= (state_d != BUF_EMPTY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in_c) begin
        main_q <= in_entry_c;
      end else if (load_main_skid_c) begin
        main_q <= skid_q;
      end
      if (load_skid_c) begin
        skid_q <= in_entry_c;
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.extended_imm = main_q.imm;
  assign bus.out_tag      = main_q.tag;
  assign bus.out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Drives XLEN=32 and XLEN=64 instances with identical traffic and checks both against a queue model.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imm_extend_pipe_if #(.DATA_BUS_WIDTH(32), .TAG_WIDTH(5)) if32 ();
  imm_extend_pipe_if #(.DATA_BUS_WIDTH(64), .TAG_WIDTH(5)) if64 ();

  imm_extend_pipe #(.DATA_BUS_WIDTH(32), .TAG_WIDTH(5)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  imm_extend_pipe #(.DATA_BUS_WIDTH(64), .TAG_WIDTH(5)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  typedef struct {
    logic [63:0] i64;
    logic [31:0] i32;
    logic [4:0]  tag;
    logic        ill;
  } ent_t;

  ent_t q[$];

  // Immediate value from the format rules, using signed arithmetic for sign extension
  function automatic logic [63:0] ref_imm(input logic [2:0] src, input logic [31:0] i, input int xlen);
    longint v;
    v = 0;
    case (src)
      3'd0: begin v = longint'(i[31:20]); if (i[31]) v = v - 64'sd4096; end
      3'd1: begin v = longint'({i[31:25], i[11:7]}); if (i[31]) v = v - 64'sd4096; end
      3'd2: begin v = longint'({i[31], i[7], i[30:25], i[11:8]}) * 64'sd2; if (i[31]) v = v - 64'sd8192; end
      3'd3: begin v = longint'({i[31], i[19:12], i[20], i[30:21]}) * 64'sd2; if (i[31]) v = v - 64'sd2097152; end
      3'd4: begin v = longint'(i[31:12]) * 64'sd4096; if (i[31]) v = v - 64'sh1_0000_0000; end
      3'd5: v = longint'(i[19:15]);
      3'd6: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'sh0000_0000_FFFF_FFFF;
    return 64'(v);
  endfunction

  function automatic ent_t mk(input logic [2:0] src, input logic [31:0] i, input logic [4:0] t);
    ent_t e;
    logic [63:0] w;
    e.i64 = ref_imm(src, i, 64);
    w     = ref_imm(src, i, 32);
    e.i32 = w[31:0];
    e.tag = t;
    e.ill = (src == 3'd7);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity two, cleared by reset or flush
  always @(posedge clk or posedge rst) begin
    bit acc;
    bit drn;
    if (rst) begin
      q.delete();
    end else if (if64.flush) begin
      q.delete();
    end else begin
      acc = if64.in_valid && (q.size() < 2);
      drn = (q.size() > 0) && if64.out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(mk(if64.imm_src, if64.instr, if64.in_tag));
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("out_valid32", 64'(if32.out_valid), 64'(q.size() != 0));
    chk("out_valid64", 64'(if64.out_valid), 64'(q.size() != 0));
    chk("in_ready32", 64'(if32.in_ready), 64'(q.size() < 2));
    chk("in_ready64", 64'(if64.in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk("imm32", 64'(if32.extended_imm), 64'(q[0].i32));
      chk("imm64", if64.extended_imm, q[0].i64);
      chk("tag32", 64'(if32.out_tag), 64'(q[0].tag));
      chk("tag64", 64'(if64.out_tag), 64'(q[0].tag));
      chk("ill32", 64'(if32.out_illegal), 64'(q[0].ill));
      chk("ill64", 64'(if64.out_illegal), 64'(q[0].ill));
    end
  end

  task automatic set_in(input logic v, input logic [2:0] s, input logic [31:0] ins,
                        input logic [4:0] t, input logic ordy, input logic fl);
    if32.in_valid = v;    if64.in_valid = v;
    if32.imm_src = s;     if64.imm_src = s;
    if32.instr = ins;     if64.instr = ins;
    if32.in_tag = t;      if64.in_tag = t;
    if32.out_ready = ordy; if64.out_ready = ordy;
    if32.flush = fl;      if64.flush = fl;
  endtask

  task automatic cyc(input logic v, input logic [2:0] s, input logic [31:0] ins,
                     input logic [4:0] t, input logic ordy, input logic fl);
    set_in(v, s, ins, t, ordy, fl);
    @(negedge clk);
  endtask

  initial begin
    set_in(1'b0, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(if64.out_valid), 64'd0);
    chk("rst_ready", 64'(if64.in_ready), 64'd1);
    chk("rst_imm64", if64.extended_imm, 64'd0);
    chk("rst_imm32", 64'(if32.extended_imm), 64'd0);
    chk("rst_tag", 64'(if64.out_tag), 64'd0);
    chk("rst_ill", 64'(if64.out_illegal), 64'd0);
    rst = 1'b0;

    // Format literals, one cycle after accept
    cyc(1'b1, 3'd0, 32'hFFF00093, 5'd4, 1'b1, 1'b0);
    chk("I_valid", 64'(if32.out_valid), 64'd1);
    chk("I_imm32", 64'(if32.extended_imm), 64'hFFFF_FFFF);
    chk("I_tag", 64'(if32.out_tag), 64'd4);
    cyc(1'b1, 3'd3, 32'hFFDFF06F, 5'd5, 1'b1, 1'b0);
    chk("J_imm32", 64'(if32.extended_imm), 64'hFFFF_FFFC);
    cyc(1'b1, 3'd4, 32'h12345037, 5'd6, 1'b1, 1'b0);
    chk("U_pos64", if64.extended_imm, 64'h0000_0000_1234_5000);
    cyc(1'b1, 3'd4, 32'h80000037, 5'd7, 1'b1, 1'b0);
    chk("U_neg64", if64.extended_imm, 64'hFFFF_FFFF_8000_0000);
    chk("U_neg32", 64'(if32.extended_imm), 64'h8000_0000);
    cyc(1'b1, 3'd5, 32'h3E0FD073, 5'd8, 1'b1, 1'b0);
    chk("Z_imm64", if64.extended_imm, 64'h1F);
    cyc(1'b1, 3'd6, 32'h03F00013, 5'd9, 1'b1, 1'b0);
    chk("SH_imm64", if64.extended_imm, 64'h3F);
    chk("SH_imm32", 64'(if32.extended_imm), 64'h1F);
    cyc(1'b1, 3'd7, 32'hDEADBEEF, 5'h15, 1'b1, 1'b0);
    chk("ILL_imm", if64.extended_imm, 64'd0);
    chk("ILL_flag", 64'(if64.out_illegal), 64'd1);
    chk("ILL_tag", 64'(if64.out_tag), 64'h15);
    cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("drained", 64'(if64.out_valid), 64'd0);

    // Backpressure: tags 1,2,3 back to back with out_ready low
    cyc(1'b1, 3'd0, 32'h00100093, 5'd1, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 32'h00200093, 5'd2, 1'b0, 1'b0);
    chk("bp_full_ready", 64'(if64.in_ready), 64'd0);
    chk("bp_head1", 64'(if64.out_tag), 64'd1);
    cyc(1'b1, 3'd0, 32'h00300093, 5'd3, 1'b0, 1'b0);
    chk("bp_hold_ready", 64'(if64.in_ready), 64'd0);
    chk("bp_hold_tag", 64'(if64.out_tag), 64'd1);
    cyc(1'b1, 3'd0, 32'h00300093, 5'd3, 1'b1, 1'b0);
    chk("bp_tag2", 64'(if64.out_tag), 64'd2);
    chk("bp_imm2", if64.extended_imm, 64'd2);
    cyc(1'b1, 3'd0, 32'h00300093, 5'd3, 1'b1, 1'b0);
    chk("bp_tag3", 64'(if64.out_tag), 64'd3);
    cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("bp_empty", 64'(if64.out_valid), 64'd0);

    // Flush in TWO with in_valid high, then flush racing an accept in ONE
    cyc(1'b1, 3'd1, 32'hFE000FA3, 5'd6, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 32'h80000863, 5'd7, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 32'h12300093, 5'd8, 1'b0, 1'b1);
    chk("fl_valid", 64'(if64.out_valid), 64'd0);
    chk("fl_ready", 64'(if64.in_ready), 64'd1);
    cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("fl_gone", 64'(if64.out_valid), 64'd0);
    cyc(1'b1, 3'd0, 32'h00900093, 5'd9, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 32'h00A00093, 5'd10, 1'b1, 1'b1);
    chk("fl_acc_drop", 64'(if64.out_valid), 64'd0);

    // Asynchronous reset while two entries are buffered
    cyc(1'b1, 3'd0, 32'h00B00093, 5'd11, 1'b0, 1'b0);
    cyc(1'b1, 3'd0, 32'h00C00093, 5'd12, 1'b0, 1'b0);
    chk("ar_two", 64'(if64.in_ready), 64'd0);
    set_in(1'b0, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(if64.out_valid), 64'd0);
    chk("ar_ready", 64'(if64.in_ready), 64'd1);
    chk("ar_tag", 64'(if32.out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, 1'b0);
    chk("ar_after", 64'(if64.out_valid), 64'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, 5'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
    end
    repeat (4) cyc(1'b0, 3'd0, 32'h0, 5'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, handshaked immediate generator for the decode stage of the pipelined core. It generalises the combinational extender to DATA_BUS_WIDTH of 32 or 64. It adds CSR zimm and shift-amount formats, flags illegal selector codes, and carries a sideband tag through a 2-entry skid buffer, so decode can stall on execute backpressure without losing an immediate. It sits between the instruction-fetch/decode register and the execute-stage operand mux.

## Interface
- DATA_BUS_WIDTH, 32, output immediate width (XLEN); only 32 and 64 are legal.
- TAG_WIDTH, 5, width of opaque sideband tag (e.g. ROB index/rd).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept this cycle
- imm_src  in  3  format select
- instr  in  32  raw instruction word
- in_tag  in  TAG_WIDTH  sideband, passed through unchanged
- out_valid  out  1  extended_imm/out_tag/out_illegal valid
- out_ready  in  1  downstream accepts
- extended_imm  out  DATA_BUS_WIDTH  sign/zero-extended immediate
- out_tag  out  TAG_WIDTH  tag matching extended_imm
- out_illegal  out  1  imm_src was 3'b111

## Operation
- Formats (S = instr[31], sign-extended to DATA_BUS_WIDTH):
  - 000 I: S-ext instr[31:20]
  - 001 S: S-ext {instr[31:25], instr[11:7]}
  - 010 B: S-ext {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: S-ext {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64
  - 101 Z: zero-ext instr[19:15] (CSR zimm)
  - 110 SH: zero-ext instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64)
  - 111: immediate 0, out_illegal=1. The entry is still transferred; it is never dropped.
- Extension is computed combinationally at the input. The main or skid register captures the result together with in_tag.
- Buffer states:
  - EMPTY: nothing buffered.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions:
  - EMPTY→ONE on accept.
  - ONE→EMPTY on drain without accept.
  - ONE→ONE on accept+drain (main reloads) or idle.
  - ONE→TWO on accept with out_ready=0 (data goes to skid).
  - TWO→ONE on drain (skid moves to main).
- Handshake rules:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
  - in_ready = (state != TWO), taken from a register with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - Outputs are held stable while out_valid & !out_ready.
- Order is strictly FIFO.
- flush forces EMPTY next cycle. An accept in the same cycle is discarded. Flush has priority over accept and drain.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible on the outputs after edge N.
- Throughput is 1/cycle while out_ready=1.
- Reset (async assert): state EMPTY, out_valid=0, in_ready=1, extended_imm=0, out_tag=0, out_illegal=0. Reset mid-transfer loses buffered entries; no partial output follows.
- Reset deassertion is synchronised externally; first accept is possible on the first edge after release.
- Datapath registers are reset as well; no X on outputs.

## Structure
- Shared package `imm_pkg`:
  - imm_src encodings as named constants IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_ILL.
  - Buffer state enum.
- Sub-module `imm_decode`: the combinational format mux, parametrised by DATA_BUS_WIDTH, with outputs imm and illegal. The top level holds only the skid buffer and control.

## Test plan
- I/J, XLEN=32: instr 0xFFF00093 src 000 → 0xFFFFFFFF; instr 0xFFDFF06F src 011 → 0xFFFFFFFC, each one cycle after accept.
- U, XLEN=64: 0x12345037 src 100 → 0x0000000012345000; 0x80000037 → 0xFFFFFFFF80000000.
- Z/SH/illegal: instr 0x3E0FD073 src 101 → 0x1F. With XLEN=64, instr with [25:20]=6'h3F, src 110 → 0x3F. Src 111 → imm 0, out_illegal=1, tag preserved.
- Backpressure: out_ready=0, push tags 1,2,3 back to back. in_ready drops after tag 2; tag 3 is held upstream. With out_ready=1, outputs 1,2,3 appear in order on consecutive cycles with no loss.
- Flush with in_valid=1 in state TWO → next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- Async rst asserted mid-clock in state TWO → out_valid=0 and in_ready=1 immediately, before the next edge.
